// File: rtl/gpio_resp_pkg.sv
// Shared types for the multi-channel GPIO responder: response modes and channel states.
package gpio_resp_pkg;

  localparam logic [1:0] MODE_OFF_ENC = 2'd3;

  typedef enum logic [1:0] {
    MODE_LEVEL  = 2'd0,
    MODE_PULSE  = 2'd1,
    MODE_TOGGLE = 2'd2,
    MODE_OFF    = MODE_OFF_ENC
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_FIRE  = 2'd2
  } state_e;

endpackage

// File: rtl/gpio_resp_ch.sv
// One responder channel: edge detect, delay counter, fire action and saturating fire counter.
module gpio_resp_ch
  import gpio_resp_pkg::*;
#(
  parameter int CntW      = 16,
  parameter int FireW     = 16,
  parameter bit Retrigger = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  mode_e            mode_i,
  input  logic [CntW-1:0]  cnt_max_i,
  input  logic             clr_i,
  input  logic             gpio_i,
  output logic             gpio_o,
  output logic             busy_o,
  output logic [FireW-1:0] fire_cnt_o
);

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [CntW-1:0]   n_q, n_d;
  logic              gpio_q;
  logic              out_q, out_d;
  logic              fire;
  logic [FireW-1:0]  fire_cnt_q, fire_cnt_d;
  logic              rise, fall;

  assign rise = gpio_i & ~gpio_q;
  assign fall = ~gpio_i & gpio_q;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    out_d   = out_q;
    fire    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rise && mode_i != MODE_OFF) begin
          mode_d  = mode_i;
          n_d     = (cnt_max_i == '0) ? CntW'(1) : cnt_max_i;
          cnt_d   = '0;
          state_d = ST_COUNT;
        end
      end
      ST_COUNT: begin
        // Abort takes precedence over a coincident fire or retrigger
        if (mode_q == MODE_LEVEL && fall) begin
          state_d = ST_IDLE;
        end else if (Retrigger && rise) begin
          cnt_d = '0;
        end else if (cnt_q == n_q - 1'b1) begin
          state_d = ST_FIRE;
          fire    = 1'b1;
          out_d   = (mode_q == MODE_TOGGLE) ? ~out_q : 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_FIRE: begin
        if (mode_q == MODE_LEVEL) begin
          if (!gpio_i) begin
            out_d   = 1'b0;
            state_d = ST_IDLE;
          end
        end else if (mode_q == MODE_PULSE) begin
          out_d   = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A clear coinciding with a fire keeps that fire
  always_comb begin
    fire_cnt_d = fire_cnt_q;
    if (clr_i) begin
      fire_cnt_d = fire ? FireW'(1) : '0;
    end else if (fire && fire_cnt_q != '1) begin
      fire_cnt_d = fire_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      gpio_q     <= 1'b0;
      out_q      <= 1'b0;
      fire_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gpio_q     <= gpio_i;
      out_q      <= out_d;
      fire_cnt_q <= fire_cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mode_q <= mode_d;
    cnt_q  <= cnt_d;
    n_q    <= n_d;
  end

  assign gpio_o     = out_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign fire_cnt_o = fire_cnt_q;

endmodule

// File: rtl/gpio_resp_multi.sv
// Multi-channel GPIO responder: NumCh independent channels sliced from flat port vectors.
module gpio_resp_multi
  import gpio_resp_pkg::*;
#(
  parameter int NumCh     = 4,
  parameter int CntW      = 16,
  parameter int FireW     = 16,
  parameter bit Retrigger = 1'b0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [2*NumCh-1:0]     mode_i,
  input  logic [NumCh*CntW-1:0]  cnt_max_i,
  input  logic [NumCh-1:0]       clr_i,
  input  logic [NumCh-1:0]       gpio_i,
  output logic [NumCh-1:0]       gpio_o,
  output logic [NumCh-1:0]       busy_o,
  output logic [NumCh*FireW-1:0] fire_cnt_o
);

  for (genvar i = 0; i < NumCh; i++) begin : g_ch
    gpio_resp_ch #(
      .CntW      (CntW),
      .FireW     (FireW),
      .Retrigger (Retrigger)
    ) u_ch (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .mode_i     (mode_e'(mode_i[2*i +: 2])),
      .cnt_max_i  (cnt_max_i[CntW*i +: CntW]),
      .clr_i      (clr_i[i]),
      .gpio_i     (gpio_i[i]),
      .gpio_o     (gpio_o[i]),
      .busy_o     (busy_o[i]),
      .fire_cnt_o (fire_cnt_o[FireW*i +: FireW])
    );
  end

endmodule

// File: tb/tb_gpio_resp_multi.sv
// Directed bench for gpio_resp_multi: default, retriggering and 2-bit fire counter variants share stimulus.
module tb_gpio_resp_multi;

  logic        clk;
  logic        rst_n;
  logic [7:0]  mode;
  logic [63:0] cnt_max;
  logic [3:0]  clr;
  logic [3:0]  gpio;

  logic [3:0]  gpio_o, busy;
  logic [63:0] fire_cnt;
  logic [3:0]  gpio_o_rt, busy_rt;
  logic [63:0] fire_cnt_rt;
  logic [3:0]  gpio_o_s, busy_s;
  logic [7:0]  fire_cnt_s;

  int checks = 0;
  int errors = 0;

  gpio_resp_multi #(.NumCh(4), .CntW(16), .FireW(16), .Retrigger(1'b0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .mode_i(mode), .cnt_max_i(cnt_max), .clr_i(clr),
    .gpio_i(gpio), .gpio_o(gpio_o), .busy_o(busy), .fire_cnt_o(fire_cnt)
  );

  gpio_resp_multi #(.NumCh(4), .CntW(16), .FireW(16), .Retrigger(1'b1)) dut_rt (
    .clk_i(clk), .rst_ni(rst_n), .mode_i(mode), .cnt_max_i(cnt_max), .clr_i(clr),
    .gpio_i(gpio), .gpio_o(gpio_o_rt), .busy_o(busy_rt), .fire_cnt_o(fire_cnt_rt)
  );

  gpio_resp_multi #(.NumCh(4), .CntW(16), .FireW(2), .Retrigger(1'b0)) dut_sat (
    .clk_i(clk), .rst_ni(rst_n), .mode_i(mode), .cnt_max_i(cnt_max), .clr_i(clr),
    .gpio_i(gpio), .gpio_o(gpio_o_s), .busy_o(busy_s), .fire_cnt_o(fire_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic tgl_exp;

  initial begin
    rst_n   = 1'b0;
    mode    = 8'hFF;
    cnt_max = '0;
    clr     = '0;
    gpio    = '0;
    tick(3);
    check("rst_gpio_o", 32'(gpio_o), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_fire_lo", fire_cnt[31:0], 32'h0);
    rst_n = 1'b1;
    tick(1);

    // Legacy LEVEL, N=16
    mode[1:0]     = 2'd0;
    cnt_max[15:0] = 16'd16;
    tick(10);
    gpio[0] = 1'b1;
    tick(1);
    check("lvl_busy_k", 32'(busy[0]), 32'h1);
    check("lvl_out_k", 32'(gpio_o[0]), 32'h0);
    tick(15);
    check("lvl_out_k15", 32'(gpio_o[0]), 32'h0);
    tick(1);
    check("lvl_out_k16", 32'(gpio_o[0]), 32'h1);
    check("lvl_fire", 32'(fire_cnt[15:0]), 32'h1);
    tick(3);
    check("lvl_hold", 32'(gpio_o[0]), 32'h1);
    check("lvl_hold_busy", 32'(busy[0]), 32'h1);
    gpio[0] = 1'b0;
    tick(1);
    check("lvl_release", 32'(gpio_o[0]), 32'h0);
    check("lvl_idle", 32'(busy[0]), 32'h0);

    // PULSE with cnt_max=0, three stimuli
    mode[3:2]      = 2'd1;
    cnt_max[31:16] = 16'd0;
    for (int i = 0; i < 3; i++) begin
      gpio[1] = 1'b1;
      tick(1);
      check("pls_k", 32'(gpio_o[1]), 32'h0);
      check("pls_busy", 32'(busy[1]), 32'h1);
      tick(1);
      check("pls_k1", 32'(gpio_o[1]), 32'h1);
      tick(1);
      check("pls_k2", 32'(gpio_o[1]), 32'h0);
      check("pls_idle", 32'(busy[1]), 32'h0);
      gpio[1] = 1'b0;
      tick(1);
    end
    check("pls_fire3", 32'(fire_cnt[31:16]), 32'd3);
    check("pls_fire3_sat", 32'(fire_cnt_s[3:2]), 32'd3);

    // TOGGLE, N=5, four rises
    mode[5:4]      = 2'd2;
    cnt_max[47:32] = 16'd5;
    tgl_exp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      gpio[2] = 1'b1;
      tick(1);
      tick(4);
      check("tgl_pre", 32'(gpio_o[2]), 32'(tgl_exp));
      tgl_exp = ~tgl_exp;
      tick(1);
      check("tgl_fire", 32'(gpio_o[2]), 32'(tgl_exp));
      gpio[2] = 1'b0;
      tick(2);
      check("tgl_persist", 32'(gpio_o[2]), 32'(tgl_exp));
      check("tgl_idle", 32'(busy[2]), 32'h0);
    end
    check("tgl_fire4", 32'(fire_cnt[47:32]), 32'd4);

    // LEVEL abort, N=20, high for 8 cycles
    cnt_max[15:0] = 16'd20;
    gpio[0] = 1'b1;
    tick(8);
    check("abt_busy", 32'(busy[0]), 32'h1);
    gpio[0] = 1'b0;
    tick(1);
    check("abt_idle", 32'(busy[0]), 32'h0);
    check("abt_out", 32'(gpio_o[0]), 32'h0);
    tick(25);
    check("abt_out_late", 32'(gpio_o[0]), 32'h0);
    check("abt_fire", 32'(fire_cnt[15:0]), 32'h1);

    // Retrigger on ch3, PULSE N=10, second rise detected at cnt=6
    mode[7:6]      = 2'd1;
    cnt_max[63:48] = 16'd10;
    gpio[3] = 1'b1;
    tick(1);
    gpio[3] = 1'b0;
    tick(6);
    gpio[3] = 1'b1;
    tick(1);
    tick(2);
    check("rt0_pre", 32'(gpio_o[3]), 32'h0);
    tick(1);
    check("rt0_fire", 32'(gpio_o[3]), 32'h1);
    check("rt1_nofire", 32'(gpio_o_rt[3]), 32'h0);
    tick(6);
    check("rt1_pre", 32'(gpio_o_rt[3]), 32'h0);
    check("rt0_done", 32'(gpio_o[3]), 32'h0);
    tick(1);
    check("rt1_fire", 32'(gpio_o_rt[3]), 32'h1);
    check("rt1_cnt", 32'(fire_cnt_rt[63:48]), 32'h1);
    check("rt0_cnt", 32'(fire_cnt[63:48]), 32'h1);
    gpio[3] = 1'b0;
    tick(2);

    // Saturation: two more pulses on ch1 (5 total)
    for (int i = 0; i < 2; i++) begin
      gpio[1] = 1'b1;
      tick(3);
      gpio[1] = 1'b0;
      tick(1);
    end
    check("sat_full", 32'(fire_cnt[31:16]), 32'd5);
    check("sat_2bit", 32'(fire_cnt_s[3:2]), 32'd3);

    // Clear on fire edge, then clear alone
    gpio[1] = 1'b1;
    tick(1);
    clr[1] = 1'b1;
    tick(1);
    clr[1] = 1'b0;
    check("clr_fire", 32'(fire_cnt[31:16]), 32'd1);
    check("clr_fire_sat", 32'(fire_cnt_s[3:2]), 32'd1);
    check("clr_out", 32'(gpio_o[1]), 32'h1);
    tick(1);
    gpio[1] = 1'b0;
    clr[1] = 1'b1;
    tick(1);
    clr[1] = 1'b0;
    check("clr_only", 32'(fire_cnt[31:16]), 32'd0);
    check("clr_only_sat", 32'(fire_cnt_s[3:2]), 32'd0);

    // Set ch2 output high so reset has something to clear
    gpio[2] = 1'b1;
    tick(6);
    check("tgl5", 32'(gpio_o[2]), 32'h1);
    gpio[2] = 1'b0;
    tick(2);

    // Reset mid-COUNT on ch0 (LEVEL, N=16)
    cnt_max[15:0] = 16'd16;
    gpio[0] = 1'b1;
    tick(6);
    check("mid_busy", 32'(busy[0]), 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out", 32'(gpio_o), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_fire_lo", fire_cnt[31:0], 32'h0);
    check("mid_rst_fire_hi", fire_cnt[63:32], 32'h0);
    tick(20);
    check("in_rst_out", 32'(gpio_o), 32'h0);
    rst_n = 1'b1;
    tick(1);
    check("rel_rise", 32'(busy[0]), 32'h1);
    gpio[0] = 1'b0;
    tick(1);
    check("rel_abort", 32'(busy[0]), 32'h0);
    tick(20);
    check("rel_out", 32'(gpio_o), 32'h0);
    check("rel_fire", 32'(fire_cnt[15:0]), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
